// File: rtl/memory_responder.sv
// memory_responder: memory side of the MFA/MFC four-phase handshake.
// Captures a request in IDLE, counts out a programmable latency in WAIT, then
// performs the byte or big-endian word access on a byte array as it enters ACK.
module memory_responder #(
  parameter int ADDR_WIDTH  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  MFA,
  input  logic                  READ_WRITE,
  input  logic                  WORD_BYTE,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [31:0]           DataIn,
  output logic [31:0]           DataOut,
  output logic                  MFC
);

  localparam int         DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t                state;
  state_t                state_next;
  logic [3:0]            wait_count;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           data_q;
  logic                  read_q;
  logic                  word_q;
  logic                  capture;
  logic                  access;
  logic [ADDR_WIDTH-1:0] addr_0;
  logic [ADDR_WIDTH-1:0] addr_1;
  logic [ADDR_WIDTH-1:0] addr_2;
  logic [ADDR_WIDTH-1:0] addr_3;
  logic [7:0]            mem [DEPTH];

  // Word byte lanes; the adds wrap naturally at the top of the address space.
  assign addr_0 = addr_q;
  assign addr_1 = addr_q + ADDR_WIDTH'(1);
  assign addr_2 = addr_q + ADDR_WIDTH'(2);
  assign addr_3 = addr_q + ADDR_WIDTH'(3);

  // Next-state and handshake decode. The capture cycle is always followed by
  // WAIT, so even a zero wait count yields MFC one edge after capture.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    access     = 1'b0;
    MFC        = 1'b0;
    case (state)
      IDLE: begin
        if (MFA) begin
          capture    = 1'b1;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (!MFA) begin
          state_next = IDLE;
        end else if (wait_count == 4'd0) begin
          access     = 1'b1;
          state_next = ACK;
        end
      end
      ACK: begin
        MFC = 1'b1;
        if (!MFA) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State register; reset forces IDLE so a pending access can never complete.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Request latch and wait counter; inputs are only looked at on capture.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wait_count <= 4'd0;
      addr_q     <= '0;
      data_q     <= 32'h0;
      read_q     <= 1'b0;
      word_q     <= 1'b0;
    end else if (capture) begin
      wait_count <= WAIT_LOAD;
      addr_q     <= Address;
      data_q     <= DataIn;
      read_q     <= READ_WRITE;
      word_q     <= WORD_BYTE;
    end else if (state == WAIT && MFA && wait_count != 4'd0) begin
      wait_count <= wait_count - 4'd1;
    end
  end

  // Read data register; holds the last read result across writes and aborts.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      DataOut <= 32'h0;
    end else if (access && read_q) begin
      if (word_q) begin
        DataOut <= {mem[addr_0], mem[addr_1], mem[addr_2], mem[addr_3]};
      end else begin
        DataOut <= {24'h0, mem[addr_0]};
      end
    end
  end

  // Array write port; contents are deliberately untouched by reset.
  always_ff @(posedge Clk) begin
    if (access && !read_q) begin
      if (word_q) begin
        mem[addr_0] <= data_q[31:24];
        mem[addr_1] <= data_q[23:16];
        mem[addr_2] <= data_q[15:8];
        mem[addr_3] <= data_q[7:0];
      end else begin
        mem[addr_0] <= data_q[7:0];
      end
    end
  end

endmodule

// File: tb/tb_memory_responder.sv
// tb_memory_responder: directed vector table plus hand-written sequences for
// reset-in-WAIT, abort, and MFA held across ACK.
module tb_memory_responder;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        MFA;
  logic        READ_WRITE;
  logic        WORD_BYTE;
  logic [7:0]  Address;
  logic [31:0] DataIn;
  logic [31:0] DataOut;
  logic        MFC;

  int vector_count = 0;
  int miss_count   = 0;

  typedef struct {
    logic        rw;
    logic        wb;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [31:0] exp_out;
  } vec_t;

  vec_t vecs [13];

  memory_responder #(.ADDR_WIDTH(8), .WAIT_CYCLES(2)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .MFA        (MFA),
    .READ_WRITE (READ_WRITE),
    .WORD_BYTE  (WORD_BYTE),
    .Address    (Address),
    .DataIn     (DataIn),
    .DataOut    (DataOut),
    .MFC        (MFC)
  );

  // Free-running clock; the initiator drives on negedge.
  always #5 Clk = ~Clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    vector_count++;
    if (actual !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic raiseRequest(input logic rw, input logic wb,
                              input logic [7:0] addr, input logic [31:0] data);
    @(negedge Clk);
    MFA        = 1'b1;
    READ_WRITE = rw;
    WORD_BYTE  = wb;
    Address    = addr;
    DataIn     = data;
  endtask

  // Returns the number of edges after the capture edge at which MFC was seen.
  task automatic waitForMfc(output int edges);
    edges = -1;
    for (int i = 0; i < 20; i++) begin
      @(posedge Clk);
      #1;
      if (MFC) begin
        edges = i;
        break;
      end
    end
  endtask

  task automatic dropRequest(input string name);
    @(negedge Clk);
    MFA = 1'b0;
    @(posedge Clk);
    #1;
    checkOutput({name, " release"}, {31'h0, MFC}, 32'h0);
  endtask

  task automatic applyStimulus(input string name, input logic rw, input logic wb,
                               input logic [7:0] addr, input logic [31:0] data,
                               input logic [31:0] exp_out);
    int lat;
    raiseRequest(rw, wb, addr, data);
    waitForMfc(lat);
    checkOutput({name, " latency"}, 32'(lat), 32'd3);
    checkOutput({name, " data"}, DataOut, exp_out);
    dropRequest(name);
  endtask

  initial begin
    int  lat;
    bit  saw_mfc;

    vecs[0]  = '{1'b0, 1'b1, 8'h10, 32'hDEADBEEF, 32'h00000000};
    vecs[1]  = '{1'b1, 1'b1, 8'h10, 32'h00000000, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 1'b0, 8'h11, 32'h00000000, 32'h000000AD};
    vecs[3]  = '{1'b0, 1'b0, 8'h12, 32'h0000005A, 32'h000000AD};
    vecs[4]  = '{1'b1, 1'b1, 8'h10, 32'h00000000, 32'hDEAD5AEF};
    vecs[5]  = '{1'b0, 1'b1, 8'hFE, 32'h11223344, 32'hDEAD5AEF};
    vecs[6]  = '{1'b1, 1'b0, 8'hFE, 32'h00000000, 32'h00000011};
    vecs[7]  = '{1'b1, 1'b0, 8'hFF, 32'h00000000, 32'h00000022};
    vecs[8]  = '{1'b1, 1'b0, 8'h00, 32'h00000000, 32'h00000033};
    vecs[9]  = '{1'b1, 1'b0, 8'h01, 32'h00000000, 32'h00000044};
    vecs[10] = '{1'b1, 1'b1, 8'hFE, 32'h00000000, 32'h11223344};
    vecs[11] = '{1'b0, 1'b0, 8'h13, 32'hFFFFFF01, 32'h11223344};
    vecs[12] = '{1'b1, 1'b1, 8'h10, 32'h00000000, 32'hDEAD5A01};

    Reset      = 1'b0;
    MFA        = 1'b0;
    READ_WRITE = 1'b1;
    WORD_BYTE  = 1'b1;
    Address    = 8'h00;
    DataIn     = 32'h0;
    #2 Reset = 1'b1;
    #1;
    checkOutput("reset MFC", {31'h0, MFC}, 32'h0);
    checkOutput("reset DataOut", DataOut, 32'h0);
    @(negedge Clk);
    Reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i].rw, vecs[i].wb,
                    vecs[i].addr, vecs[i].data, vecs[i].exp_out);
    end

    // Reset asserted in the last WAIT cycle must cancel the pending write.
    raiseRequest(1'b0, 1'b1, 8'h10, 32'h0BADF00D);
    @(posedge Clk);
    @(posedge Clk);
    @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b1;
    #1;
    checkOutput("midwait reset MFC", {31'h0, MFC}, 32'h0);
    checkOutput("midwait reset DataOut", DataOut, 32'h0);
    MFA = 1'b0;
    @(posedge Clk);
    #1;
    checkOutput("reset held MFC", {31'h0, MFC}, 32'h0);
    @(negedge Clk);
    Reset = 1'b0;
    applyStimulus("after reset", 1'b1, 1'b1, 8'h10, 32'h0, 32'hDEAD5A01);

    // Abort: MFA drops after one WAIT cycle, so MFC must never rise.
    raiseRequest(1'b0, 1'b1, 8'h10, 32'h55667788);
    @(posedge Clk);
    @(posedge Clk);
    @(negedge Clk);
    MFA = 1'b0;
    saw_mfc = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge Clk);
      #1;
      if (MFC) saw_mfc = 1'b1;
    end
    checkOutput("abort MFC", {31'h0, saw_mfc}, 32'h0);
    applyStimulus("after abort", 1'b1, 1'b1, 8'h10, 32'h0, 32'hDEAD5A01);

    // Held MFA: a write presented during ACK must not be taken as a new request.
    raiseRequest(1'b1, 1'b1, 8'h10, 32'h0);
    waitForMfc(lat);
    checkOutput("held latency", 32'(lat), 32'd3);
    checkOutput("held data", DataOut, 32'hDEAD5A01);
    @(negedge Clk);
    READ_WRITE = 1'b0;
    WORD_BYTE  = 1'b1;
    Address    = 8'h10;
    DataIn     = 32'hFFFFFFFF;
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk);
      #1;
      checkOutput($sformatf("held MFC %0d", i), {31'h0, MFC}, 32'h1);
      checkOutput($sformatf("held stable %0d", i), DataOut, 32'hDEAD5A01);
    end
    dropRequest("held");
    raiseRequest(1'b1, 1'b0, 8'h12, 32'h0);
    waitForMfc(lat);
    checkOutput("rearm latency", 32'(lat), 32'd3);
    checkOutput("rearm data", DataOut, 32'h0000005A);
    dropRequest("rearm");
    applyStimulus("after held", 1'b1, 1'b1, 8'h10, 32'h0, 32'hDEAD5A01);

    $display("== %0d vectors applied, %0d miscompares ==", vector_count, miss_count);
    $finish;
  end

endmodule
